// File: rtl/div_pkg.sv
// Shared constants and FSM state encoding for the divider exponent path.
package div_pkg;
    localparam int EW      = 8;
    localparam int BIAS    = (1 << (EW - 1)) - 1;
    localparam int EXP_MAX = (1 << EW) - 1;

    // Sequencing of the shared adder: subtract, add bias, wait, adjust, hold
    typedef enum logic [2:0] {
        S_IDLE,
        S_SUB,
        S_BIAS,
        S_WNORM,
        S_ADJ,
        S_DONE
    } state_t;
endpackage

// File: rtl/exp_addsub.sv
// Single shared adder: y = a + b, or a + ~b + 1 when sub is set.
module exp_addsub #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);
    import div_pkg::*;

    logic [W-1:0] b_eff;

    // Subtraction reuses the adder by inverting b and injecting carry-in
    always_comb begin
        b_eff = sub ? ~b : b;
        y     = a + b_eff + {{(W-1){1'b0}}, sub};
    end
endmodule

// File: rtl/div_exp_seq.sv
// Quotient exponent sequencer: exp_q = exp_a - exp_b + BIAS - norm_dec,
// computed over several cycles on one shared adder, saturated on output.
// Optional build macro DIV_EXP_SPECIAL_EN adds a fast path for zero /
// all-ones exponents and a 'special' output flag.
module div_exp_seq #(
    parameter int EW   = div_pkg::EW,
    parameter int BIAS = div_pkg::BIAS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] exp_a,
    input  logic [EW-1:0] exp_b,
    input  logic          norm_valid,
    input  logic          norm_dec,
    output logic          norm_ack,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] exp_q,
    output logic          ovf,
`ifdef DIV_EXP_SPECIAL_EN
    output logic          unf,
    output logic          special
`else
    output logic          unf
`endif
);
    import div_pkg::*;

    localparam int AW   = EW + 2;
    localparam int EMAX = (1 << EW) - 1;

    state_t               state, state_nx;
    logic [EW-1:0]        ra, rb;
    logic signed [AW-1:0] acc;
    logic                 nd;
    logic [AW-1:0]        add_a, add_b, add_y;
    logic                 add_sub;
    logic                 is_special;

`ifdef DIV_EXP_SPECIAL_EN
    assign is_special = (ra == '0) || (ra == {EW{1'b1}}) ||
                        (rb == '0) || (rb == {EW{1'b1}});
`else
    assign is_special = 1'b0;
`endif

    exp_addsub #(.W(AW)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .y   (add_y)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state, handshake outputs and per-state adder operand select
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        norm_ack  = 1'b0;
        out_valid = 1'b0;
        add_a     = $unsigned(acc);
        add_b     = '0;
        add_sub   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_SUB;
            end
            S_SUB: begin
                add_a    = {2'b00, ra};
                add_b    = {2'b00, rb};
                add_sub  = 1'b1;
                state_nx = is_special ? S_DONE : S_BIAS;
            end
            S_BIAS: begin
                add_b    = AW'(BIAS);
                state_nx = S_WNORM;
            end
            S_WNORM: begin
                // A flag arriving alongside reset is left for the next op
                if (norm_valid) begin
                    norm_ack = ~rst;
                    state_nx = S_ADJ;
                end
            end
            S_ADJ: begin
                add_b    = {{(AW-1){1'b0}}, nd};
                add_sub  = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latch, accumulator, and result classification on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            acc   <= '0;
            nd    <= 1'b0;
            exp_q <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
`ifdef DIV_EXP_SPECIAL_EN
            special <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ra <= exp_a;
                        rb <= exp_b;
                    end
                end
                S_SUB: begin
                    acc <= $signed(add_y);
`ifdef DIV_EXP_SPECIAL_EN
                    if (is_special) begin
                        special <= 1'b1;
                        ovf     <= 1'b0;
                        unf     <= 1'b0;
                        exp_q   <= ((ra == {EW{1'b1}}) || (rb == '0)) ? {EW{1'b1}} : '0;
                    end
`endif
                end
                S_BIAS:  acc <= $signed(add_y);
                S_WNORM: if (norm_valid) nd <= norm_dec;
                S_ADJ: begin
                    acc <= $signed(add_y);
`ifdef DIV_EXP_SPECIAL_EN
                    special <= 1'b0;
`endif
                    if ($signed(add_y) >= EMAX) begin
                        exp_q <= {EW{1'b1}};
                        ovf   <= 1'b1;
                        unf   <= 1'b0;
                    end else if ($signed(add_y) <= 0) begin
                        exp_q <= '0;
                        ovf   <= 1'b0;
                        unf   <= 1'b1;
                    end else begin
                        exp_q <= add_y[EW-1:0];
                        ovf   <= 1'b0;
                        unf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_exp_seq.sv
// Directed bench for div_exp_seq: vector table plus handshake/reset corners.
module tb_div_exp_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, norm_valid = 1'b0, norm_dec = 1'b0, out_ready = 1'b0;
    logic [7:0] exp_a = '0, exp_b = '0;
    logic       in_ready, norm_ack, out_valid, ovf, unf;
    logic [7:0] exp_q;
`ifdef DIV_EXP_SPECIAL_EN
    logic       special;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_exp_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .norm_valid (norm_valid),
        .norm_dec   (norm_dec),
        .norm_ack   (norm_ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_q      (exp_q),
        .ovf        (ovf),
`ifdef DIV_EXP_SPECIAL_EN
        .unf        (unf),
        .special    (special)
`else
        .unf        (unf)
`endif
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       nd;
        int         nv;   // cycle (relative to accept) norm_valid first rises
        logic [7:0] q;
        logic       eo;
        logic       eu;
    } vec_t;

    // One operation: accept in cycle 0, count cycles to norm_ack / out_valid,
    // optionally stall the result for 'hold' cycles, then handshake.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic nd, input int nv, input int hold,
                          input logic [7:0] q, input logic eo, input logic eu);
        int ack_at, done_at, acks, exp_ack;
        @(negedge clk);
        exp_a = a; exp_b = b; norm_dec = nd; in_valid = 1'b1; norm_valid = (nv <= 0);
        #1;
        chk({tag, " in_ready"}, in_ready, 1);
        ack_at = -1; done_at = -1; acks = 0;
        for (int k = 1; k < 80 && done_at < 0; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            norm_valid = (k >= nv) && (ack_at < 0);
            #1;
            if (norm_ack) begin
                acks++;
                if (ack_at < 0) ack_at = k;
            end
            if (out_valid) done_at = k;
        end
        norm_valid = 1'b0;
        exp_ack = (nv > 3) ? nv : 3;
        chk({tag, " ack_cycle"}, ack_at, exp_ack);
        chk({tag, " ack_count"}, acks, 1);
        chk({tag, " done_cycle"}, done_at, exp_ack + 2);
        if (done_at < 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        chk({tag, " exp_q"}, exp_q, q);
        chk({tag, " ovf"}, ovf, eo);
        chk({tag, " unf"}, unf, eu);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1; exp_a = 8'd5; exp_b = 8'd5;
            #1;
            chk({tag, " stall in_ready"}, in_ready, 0);
            chk({tag, " stall out_valid"}, out_valid, 1);
            chk({tag, " stall exp_q"}, {exp_q, ovf, unf}, {q, eo, eu});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk({tag, " after out_valid"}, out_valid, 0);
        chk({tag, " after in_ready"}, in_ready, 1);
    endtask

`ifdef DIV_EXP_SPECIAL_EN
    task automatic special_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] q);
        int done_at, acks;
        @(negedge clk);
        exp_a = a; exp_b = b; in_valid = 1'b1; norm_valid = 1'b1;
        done_at = -1; acks = 0;
        for (int k = 1; k < 20 && done_at < 0; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (norm_ack) acks++;
            if (out_valid) done_at = k;
        end
        norm_valid = 1'b0;
        chk({tag, " done_cycle"}, done_at, 2);
        chk({tag, " acks"}, acks, 0);
        chk({tag, " special"}, special, 1);
        chk({tag, " exp_q"}, exp_q, q);
        chk({tag, " flags"}, {ovf, unf}, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    vec_t vt[9];

    initial begin
        vt[0] = '{8'd130, 8'd127, 1'b0, 0,  8'd130, 1'b0, 1'b0};
        vt[1] = '{8'd127, 8'd127, 1'b1, 13, 8'd126, 1'b0, 1'b0};
        vt[2] = '{8'd200, 8'd10,  1'b0, 0,  8'd255, 1'b1, 1'b0};
        vt[3] = '{8'd10,  8'd200, 1'b0, 0,  8'd0,   1'b0, 1'b1};
        vt[4] = '{8'd1,   8'd127, 1'b0, 0,  8'd1,   1'b0, 1'b0};
        vt[5] = '{8'd1,   8'd127, 1'b1, 0,  8'd0,   1'b0, 1'b1};
        vt[6] = '{8'd128, 8'd1,   1'b0, 2,  8'd254, 1'b0, 1'b0};
        vt[7] = '{8'd129, 8'd1,   1'b0, 0,  8'd255, 1'b1, 1'b0};
        vt[8] = '{8'd128, 8'd1,   1'b1, 5,  8'd253, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset norm_ack", norm_ack, 0);
        chk("reset results", {exp_q, ovf, unf}, 0);
        rst = 1'b0;

        foreach (vt[i])
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].nd, vt[i].nv, 0,
                   vt[i].q, vt[i].eo, vt[i].eu);

        // Stalled result with in_valid pulsing meanwhile
        run_op("stall", 8'd130, 8'd127, 1'b0, 0, 5, 8'd130, 1'b0, 1'b0);

        // Reset while waiting for the normalisation flag
        @(negedge clk);
        exp_a = 8'd100; exp_b = 8'd50; in_valid = 1'b1; norm_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("wnorm wait ack c%0d", k), norm_ack, 0);
        end
        @(negedge clk);
        rst = 1'b1; norm_valid = 1'b1;
        #1;
        chk("rst cycle norm_ack", norm_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post rst in_ready", in_ready, 1);
        chk("post rst out_valid", out_valid, 0);
        chk("post rst norm_ack", norm_ack, 0);
        chk("post rst exp_q", exp_q, 0);
        norm_valid = 1'b0;
        run_op("post rst op", 8'd130, 8'd127, 1'b0, 0, 0, 8'd130, 1'b0, 1'b0);

`ifdef DIV_EXP_SPECIAL_EN
        special_op("sp a_max", 8'd255, 8'd3,   8'd255);
        special_op("sp b_zero", 8'd7,  8'd0,   8'd255);
        special_op("sp b_max", 8'd5,   8'd255, 8'd0);
        special_op("sp a_zero", 8'd0,  8'd9,   8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_exp_seq.md
Name: div_exp_seq

Overview:
- Multi-cycle controller that computes the quotient exponent for the floating-point divider as exp_q = exp_a - exp_b + BIAS - norm_dec.
- Uses one shared (EW+2)-bit adder. A small FSM selects the adder operands on successive cycles: subtract, add bias, normalise.
- Sits between the operand unpacker (upstream valid/ready) and the result packer (downstream valid/ready).
- Waits on the mantissa divider's normalisation flag before the final adjust.

Parameters:
- EW, 8, exponent field width.
- BIAS, 127, exponent bias; must be 2^(EW-1)-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand exponents valid.
- in_ready  output  1  block can accept operands.
- exp_a  input  EW  dividend biased exponent.
- exp_b  input  EW  divisor biased exponent.
- norm_valid  input  1  norm_dec is valid, from the mantissa divider.
- norm_dec  input  1  1 means the quotient mantissa is < 1 and the exponent must be decremented.
- norm_ack  output  1  one-cycle pulse when norm_dec is consumed.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- exp_q  output  EW  result exponent, saturated.
- ovf  output  1  exponent overflow.
- unf  output  1  exponent underflow.

Behaviour:
- Clocking: one clock; rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, norm_ack=0, exp_q=0, ovf=0, unf=0, accumulator acc=0.
- Arithmetic:
  - acc is a signed (EW+2)-bit register. Operands are zero-extended to EW+2 bits.
  - Subtraction is done as acc + ~b + 1 on the shared adder.
  - There is exactly one adder instance; per-state operand muxes feed it.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch exp_a/exp_b and go to SUB.
  - SUB: acc <= exp_a - exp_b. Go to BIAS.
  - BIAS: acc <= acc + BIAS. Go to WNORM.
  - WNORM: hold until norm_valid=1. In the cycle norm_valid=1, pulse norm_ack=1 and latch norm_dec. Go to ADJ.
  - ADJ: acc <= acc - norm_dec. Go to DONE.
  - DONE: out_valid=1 and outputs are stable. On out_ready, go to IDLE with out_valid=0 and in_ready=1 on the next cycle.
- Latency: operands accepted in cycle T. If norm_valid is already high, norm_ack pulses at T+3 and out_valid rises at T+5. Otherwise the latency extends by the WNORM wait.
- Result classification, evaluated on the final acc at entry to DONE:
  - acc >= 2^EW - 1 (255): ovf=1, unf=0, exp_q=all ones.
  - acc <= 0: unf=1, ovf=0, exp_q=0.
  - Otherwise: exp_q=acc[EW-1:0], ovf=unf=0.
- Handshake rules:
  - in_ready=0 in every state except IDLE, so no second operand pair is accepted while busy.
  - norm_valid is ignored outside WNORM, and norm_ack is never asserted outside WNORM.
  - With out_valid=1 and out_ready=0, exp_q, ovf and unf hold indefinitely.
- Boundaries:
  - exp_a=exp_b gives BIAS-norm_dec.
  - The minimum normal result is 1; a result of 1 is not underflow.
  - Full-range inputs (0..255) never wrap the (EW+2)-bit accumulator.
- Reset mid-operation: rst in any state returns to IDLE with reset values next cycle. A pending norm_valid is not acked.

Optional Feature:
- Macro: DIV_EXP_SPECIAL_EN.
- When defined:
  - In SUB, if exp_a or exp_b is 0 or all ones, the FSM skips BIAS, WNORM and ADJ and goes straight to DONE. norm_ack is not pulsed.
  - An extra output port special (1 bit) is added and is 1 for the skipped result.
  - Result values: exp_a=255 or exp_b=0 gives exp_q=255, ovf=0. Otherwise exp_q=0, unf=0.
  - Priority when several conditions hold: exp_a all-ones first, then exp_b zero.
- When undefined: no special port; all exponents follow the normal path.

Decomposition:
- Shared package div_pkg: the EW and BIAS constants, the FSM state enum (IDLE, SUB, BIAS, WNORM, ADJ, DONE), and the EXP_MAX=2^EW-1 constant.
- One natural sub-module, exp_addsub: an (EW+2)-bit adder with a subtract control, inverting b and injecting carry-in. It is instanced once.

Test Plan:
- exp_a=130, exp_b=127, norm_valid=1 held, norm_dec=0 -> out_valid at T+5, exp_q=130, ovf=0, unf=0.
- exp_a=127, exp_b=127, norm_dec=1 delivered 10 cycles late -> no norm_ack before the norm_valid cycle, exp_q=126.
- exp_a=200, exp_b=10 -> ovf=1, exp_q=255. Then exp_a=10, exp_b=200 -> unf=1, exp_q=0.
- exp_a=1, exp_b=127, norm_dec=0 -> exp_q=1, unf=0. Same operands with norm_dec=1 -> exp_q=0, unf=1.
- Hold out_ready=0 for 5 cycles and pulse in_valid meanwhile -> outputs stable, in_ready=0, second operand pair not accepted until after the handshake.
- Assert rst during WNORM -> next cycle in_ready=1, out_valid=0, no norm_ack. A new operation then completes correctly.
